tank_bullet_ctrl: RTL and testbench

Per-tank bullet engine and the producer side of the collision interface. It launches a bullet on a fire request, moves it once per frame tick, and drives the per-pixel bullet hit signal that the collision block consumes as its bullet input. It reacts to the collision block's bullet-explode signal and to screen edges by playing a timed explosion, then enforces a cooldown before the next shot. One instance is used per player tank and per enemy tank.

---
 rtl/tank_bullet_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_tank_bullet_ctrl.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/tank_bullet_ctrl.sv
// Per-tank bullet engine: fire acceptance, flight, timed explosion and cooldown,
// plus per-pixel bullet/explosion hit outputs consumed by the collision block.
module tank_bullet_ctrl #(
    parameter int SCREEN_W        = 640,
    parameter int SCREEN_H        = 480,
    parameter int TANK_SIZE       = 16,
    parameter int BULLET_SIZE     = 4,
    parameter int SPEED           = 2,
    parameter int EXPLODE_SIZE    = 16,
    parameter int EXPLODE_FRAMES  = 8,
    parameter int COOLDOWN_FRAMES = 4
) (
    input  logic       clk_i,
    input  logic       reset_all_i,
    input  logic       frame_tick_i,
    input  logic       fire_i,
    input  logic       tank_alive_i,
    input  logic [9:0] tank_x_i,
    input  logic [9:0] tank_y_i,
    input  logic [1:0] tank_dir_i,
    input  logic [9:0] pixel_x_i,
    input  logic [9:0] pixel_y_i,
    input  logic       explose_i,
    output logic       bullet_pix_o,
    output logic       explode_pix_o,
    output logic       bullet_active_o,
    output logic       shot_fired_o,
    output logic [9:0] bullet_x_o,
    output logic [9:0] bullet_y_o
);
    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_FLYING    = 2'd1,
        ST_EXPLODING = 2'd2,
        ST_COOLDOWN  = 2'd3
    } state_t;

    localparam logic [9:0]  SPEED_P   = 10'(SPEED);
    localparam logic [9:0]  SPAWN_OFF = 10'((TANK_SIZE - BULLET_SIZE) / 2);
    localparam logic [9:0]  SPAWN_FAR = 10'(TANK_SIZE - BULLET_SIZE);
    localparam logic [10:0] SPEED_W   = 11'(SPEED);
    localparam logic [10:0] BS_W      = 11'(BULLET_SIZE);
    localparam logic [10:0] ES_W      = 11'(EXPLODE_SIZE);
    localparam logic [10:0] EXP_OFF   = 11'((EXPLODE_SIZE - BULLET_SIZE) / 2);
    localparam logic [10:0] SCR_W     = 11'(SCREEN_W);
    localparam logic [10:0] SCR_H     = 11'(SCREEN_H);
    localparam logic [7:0]  EXP_LAST  = 8'(EXPLODE_FRAMES - 1);
    localparam logic [7:0]  COOL_LAST = 8'(COOLDOWN_FRAMES - 1);

    state_t      state_r, state_s;
    logic [9:0]  bx_r, by_r, bx_s, by_s;
    logic [9:0]  spawn_x_s, spawn_y_s, step_x_s, step_y_s;
    logic [1:0]  dir_r, dir_s;
    logic [7:0]  cnt_r, cnt_s;
    logic        shot_r, shot_s;
    logic        edge_s;
    logic [10:0] bx_ext_s, by_ext_s, px_s, py_s, ex_s, ey_s;

    assign bx_ext_s = {1'b0, bx_r};
    assign by_ext_s = {1'b0, by_r};
    assign px_s     = {1'b0, pixel_x_i};
    assign py_s     = {1'b0, pixel_y_i};

    // Spawn position at the muzzle side of the tank box
    always_comb begin
        spawn_x_s = tank_x_i + SPAWN_OFF;
        spawn_y_s = tank_y_i;
        case (tank_dir_i)
            2'd0: begin spawn_x_s = tank_x_i + SPAWN_OFF; spawn_y_s = tank_y_i;             end
            2'd1: begin spawn_x_s = tank_x_i + SPAWN_FAR; spawn_y_s = tank_y_i + SPAWN_OFF; end
            2'd2: begin spawn_x_s = tank_x_i + SPAWN_OFF; spawn_y_s = tank_y_i + SPAWN_FAR; end
            2'd3: begin spawn_x_s = tank_x_i;             spawn_y_s = tank_y_i + SPAWN_OFF; end
            default: begin spawn_x_s = tank_x_i; spawn_y_s = tank_y_i; end
        endcase
    end

    // Screen-edge check and one-step move in the latched direction
    always_comb begin
        edge_s   = 1'b0;
        step_x_s = bx_r;
        step_y_s = by_r;
        case (dir_r)
            2'd0: begin edge_s = (by_ext_s < SPEED_W);                 step_y_s = by_r - SPEED_P; end
            2'd1: begin edge_s = (bx_ext_s + BS_W + SPEED_W > SCR_W);  step_x_s = bx_r + SPEED_P; end
            2'd2: begin edge_s = (by_ext_s + BS_W + SPEED_W > SCR_H);  step_y_s = by_r + SPEED_P; end
            2'd3: begin edge_s = (bx_ext_s < SPEED_W);                 step_x_s = bx_r - SPEED_P; end
            default: begin edge_s = 1'b0; step_x_s = bx_r; step_y_s = by_r; end
        endcase
    end

    // Next-state logic: fire acceptance, flight, explosion and cooldown timing
    always_comb begin
        state_s = state_r;
        bx_s    = bx_r;
        by_s    = by_r;
        dir_s   = dir_r;
        cnt_s   = cnt_r;
        shot_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (fire_i && tank_alive_i) begin
                    state_s = ST_FLYING;
                    dir_s   = tank_dir_i;
                    bx_s    = spawn_x_s;
                    by_s    = spawn_y_s;
                    cnt_s   = 8'd0;
                    shot_s  = 1'b1;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_FLYING: begin
                if (explose_i) begin
                    state_s = ST_EXPLODING;
                    cnt_s   = 8'd0;
                end else if (frame_tick_i) begin
                    if (edge_s) begin
                        state_s = ST_EXPLODING;
                        cnt_s   = 8'd0;
                    end else begin
                        bx_s = step_x_s;
                        by_s = step_y_s;
                    end
                end else begin
                    state_s = ST_FLYING;
                end
            end
            ST_EXPLODING: begin
                if (frame_tick_i) begin
                    if (cnt_r == EXP_LAST) begin
                        state_s = ST_COOLDOWN;
                        cnt_s   = 8'd0;
                    end else begin
                        cnt_s = cnt_r + 8'd1;
                    end
                end else begin
                    cnt_s = cnt_r;
                end
            end
            ST_COOLDOWN: begin
                if (frame_tick_i) begin
                    if (cnt_r == COOL_LAST) begin
                        state_s = ST_IDLE;
                        cnt_s   = 8'd0;
                    end else begin
                        cnt_s = cnt_r + 8'd1;
                    end
                end else begin
                    cnt_s = cnt_r;
                end
            end
            default: begin
                state_s = ST_IDLE;
                cnt_s   = 8'd0;
            end
        endcase
    end

    // State, position and pulse registers
    always_ff @(posedge clk_i or posedge reset_all_i) begin
        if (reset_all_i) begin
            state_r <= ST_IDLE;
            bx_r    <= 10'd0;
            by_r    <= 10'd0;
            dir_r   <= 2'd0;
            cnt_r   <= 8'd0;
            shot_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            bx_r    <= bx_s;
            by_r    <= by_s;
            dir_r   <= dir_s;
            cnt_r   <= cnt_s;
            shot_r  <= shot_s;
        end
    end

    // Explosion box is centred on the bullet, clamped at the top/left screen edge
    assign ex_s = (bx_ext_s >= EXP_OFF) ? (bx_ext_s - EXP_OFF) : 11'd0;
    assign ey_s = (by_ext_s >= EXP_OFF) ? (by_ext_s - EXP_OFF) : 11'd0;

    assign bullet_pix_o  = (state_r == ST_FLYING) &&
                           (px_s >= bx_ext_s) && (px_s < bx_ext_s + BS_W) &&
                           (py_s >= by_ext_s) && (py_s < by_ext_s + BS_W);
    assign explode_pix_o = (state_r == ST_EXPLODING) &&
                           (px_s >= ex_s) && (px_s < ex_s + ES_W) &&
                           (py_s >= ey_s) && (py_s < ey_s + ES_W);

    assign bullet_active_o = (state_r == ST_FLYING);
    assign shot_fired_o    = shot_r;
    assign bullet_x_o      = bx_r;
    assign bullet_y_o      = by_r;
endmodule

// File: tb/tb_tank_bullet_ctrl.sv
// Randomized and directed bench for tank_bullet_ctrl against a behavioural bullet model.
module tb_tank_bullet_ctrl;
    logic       clk_i = 1'b0;
    logic       reset_all_i = 1'b0;
    logic       frame_tick_i = 1'b0, fire_i = 1'b0, tank_alive_i = 1'b1, explose_i = 1'b0;
    logic [9:0] tank_x_i = 10'd0, tank_y_i = 10'd0, pixel_x_i = 10'd0, pixel_y_i = 10'd0;
    logic [1:0] tank_dir_i = 2'd0;
    logic       bullet_pix_o, explode_pix_o, bullet_active_o, shot_fired_o;
    logic [9:0] bullet_x_o, bullet_y_o;

    tank_bullet_ctrl dut (
        .clk_i(clk_i), .reset_all_i(reset_all_i), .frame_tick_i(frame_tick_i),
        .fire_i(fire_i), .tank_alive_i(tank_alive_i), .tank_x_i(tank_x_i),
        .tank_y_i(tank_y_i), .tank_dir_i(tank_dir_i), .pixel_x_i(pixel_x_i),
        .pixel_y_i(pixel_y_i), .explose_i(explose_i), .bullet_pix_o(bullet_pix_o),
        .explode_pix_o(explode_pix_o), .bullet_active_o(bullet_active_o),
        .shot_fired_o(shot_fired_o), .bullet_x_o(bullet_x_o), .bullet_y_o(bullet_y_o)
    );

    always #5 clk_i = ~clk_i;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: what the bullet is doing, where it is, ticks remaining in a phase
    localparam int M_IDLE = 0, M_FLY = 1, M_EXPL = 2, M_COOL = 3;
    int m_mode = M_IDLE, m_x = 0, m_y = 0, m_dir = 0, m_left = 0;
    int m_shot = 0;

    task automatic check_val(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int in_box(input int px, input int py, input int x, input int y, input int s);
        return (px >= x && px < x + s && py >= y && py < y + s) ? 1 : 0;
    endfunction

    task automatic model_clock();
        int dx, dy, nx, ny;
        m_shot = 0;
        case (m_mode)
            M_IDLE: if (fire_i && tank_alive_i) begin
                m_dir  = int'(tank_dir_i);
                m_shot = 1;
                m_mode = M_FLY;
                case (m_dir)
                    0: begin m_x = int'(tank_x_i) + 6;  m_y = int'(tank_y_i);      end
                    1: begin m_x = int'(tank_x_i) + 12; m_y = int'(tank_y_i) + 6;  end
                    2: begin m_x = int'(tank_x_i) + 6;  m_y = int'(tank_y_i) + 12; end
                    default: begin m_x = int'(tank_x_i); m_y = int'(tank_y_i) + 6; end
                endcase
            end
            M_FLY: if (explose_i) begin
                m_mode = M_EXPL; m_left = 8;
            end else if (frame_tick_i) begin
                dx = (m_dir == 1) ? 2 : (m_dir == 3) ? -2 : 0;
                dy = (m_dir == 2) ? 2 : (m_dir == 0) ? -2 : 0;
                nx = m_x + dx;
                ny = m_y + dy;
                if (nx < 0 || ny < 0 || nx + 4 > 640 || ny + 4 > 480) begin
                    m_mode = M_EXPL; m_left = 8;
                end else begin
                    m_x = nx; m_y = ny;
                end
            end
            M_EXPL: if (frame_tick_i) begin
                m_left--;
                if (m_left == 0) begin m_mode = M_COOL; m_left = 4; end
            end
            default: if (frame_tick_i) begin
                m_left--;
                if (m_left == 0) m_mode = M_IDLE;
            end
        endcase
    endtask

    task automatic check_all();
        int ex, ey, bx, by, r, px, py;
        ex = (m_x > 6) ? m_x - 6 : 0;
        ey = (m_y > 6) ? m_y - 6 : 0;
        bx = (m_mode == M_EXPL) ? ex : m_x;
        by = (m_mode == M_EXPL) ? ey : m_y;
        r  = int'($urandom_range(0, 21)); px = bx - 2 + r;
        r  = int'($urandom_range(0, 21)); py = by - 2 + r;
        if (px < 0) px = 0;
        if (py < 0) py = 0;
        pixel_x_i = 10'(px);
        pixel_y_i = 10'(py);
        #1;
        check_val("shot", int'(shot_fired_o), m_shot);
        check_val("active", int'(bullet_active_o), (m_mode == M_FLY) ? 1 : 0);
        check_val("bx", int'(bullet_x_o), m_x);
        check_val("by", int'(bullet_y_o), m_y);
        check_val("bpix", int'(bullet_pix_o), (m_mode == M_FLY) ? in_box(px, py, m_x, m_y, 4) : 0);
        check_val("epix", int'(explode_pix_o), (m_mode == M_EXPL) ? in_box(px, py, ex, ey, 16) : 0);
    endtask

    task automatic cyc(input bit f, input bit t, input bit e);
        fire_i = f; frame_tick_i = t; explose_i = e;
        @(posedge clk_i);
        model_clock();
        #1;
        check_all();
    endtask

    task automatic pix_at(input string tag, input int px, input int py, input int eb, input int ee);
        pixel_x_i = 10'(px);
        pixel_y_i = 10'(py);
        #1;
        check_val({tag, "_bpix"}, int'(bullet_pix_o), eb);
        check_val({tag, "_epix"}, int'(explode_pix_o), ee);
    endtask

    // Reset asserted between clock edges; outputs must clear before any edge
    task automatic do_reset();
        #2;
        reset_all_i = 1'b1;
        #1;
        check_val("rst_shot", int'(shot_fired_o), 0);
        check_val("rst_active", int'(bullet_active_o), 0);
        check_val("rst_bx", int'(bullet_x_o), 0);
        check_val("rst_by", int'(bullet_y_o), 0);
        check_val("rst_bpix", int'(bullet_pix_o), 0);
        check_val("rst_epix", int'(explode_pix_o), 0);
        @(posedge clk_i);
        #1;
        reset_all_i = 1'b0;
        m_mode = M_IDLE; m_x = 0; m_y = 0; m_dir = 0; m_left = 0; m_shot = 0;
    endtask

    task automatic set_tank(input int x, input int y, input int d, input bit a);
        tank_x_i = 10'(x); tank_y_i = 10'(y); tank_dir_i = 2'(d); tank_alive_i = a;
    endtask

    initial begin
        int shots;
        do_reset();

        // Fire upward and fly three frames
        set_tank(100, 200, 0, 1'b1);
        cyc(1'b1, 1'b0, 1'b0);
        check_val("t1_shot", int'(shot_fired_o), 1);
        check_val("t1_x", int'(bullet_x_o), 106);
        check_val("t1_y", int'(bullet_y_o), 200);
        check_val("t1_active", int'(bullet_active_o), 1);
        cyc(1'b0, 1'b0, 1'b0);
        check_val("t1_pulse_end", int'(shot_fired_o), 0);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b0);
        check_val("t1_y_moved", int'(bullet_y_o), 194);

        // Screen-edge explosion at the left edge, then cooldown
        do_reset();
        set_tank(0, 0, 3, 1'b1);
        cyc(1'b1, 1'b0, 1'b0);
        check_val("t2_x", int'(bullet_x_o), 0);
        check_val("t2_y", int'(bullet_y_o), 6);
        cyc(1'b0, 1'b1, 1'b0);
        pix_at("t2_org", 0, 0, 0, 1);
        pix_at("t2_far", 15, 15, 0, 1);
        pix_at("t2_out", 16, 0, 0, 0);
        for (int i = 0; i < 7; i++) cyc(1'b0, 1'b1, 1'b0);
        pix_at("t2_last", 0, 0, 0, 1);
        cyc(1'b0, 1'b1, 1'b0);
        pix_at("t2_cool", 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        check_val("t2_cool_fire", int'(shot_fired_o), 0);
        cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        check_val("t2_refire", int'(shot_fired_o), 1);

        // Collision in the same cycle as a frame tick, then fire held throughout
        do_reset();
        set_tank(288, 94, 1, 1'b1);
        cyc(1'b1, 1'b0, 1'b0);
        check_val("t3_x", int'(bullet_x_o), 300);
        cyc(1'b1, 1'b1, 1'b1);
        check_val("t3_x_frozen", int'(bullet_x_o), 300);
        pix_at("t3_in", 294, 94, 0, 1);
        pix_at("t3_out", 310, 94, 0, 0);
        shots = 0;
        for (int i = 0; i < 12; i++) begin
            cyc(1'b1, 1'b1, 1'b0);
            shots += int'(shot_fired_o);
        end
        check_val("t4_held", shots, 0);
        cyc(1'b1, 1'b0, 1'b0);
        check_val("t4_idle_fire", int'(shot_fired_o), 1);

        // Dead tank cannot fire
        do_reset();
        set_tank(300, 300, 2, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        check_val("t4_dead", int'(shot_fired_o), 0);

        // Half-open bullet box
        set_tank(44, 60, 0, 1'b1);
        cyc(1'b1, 1'b0, 1'b0);
        pix_at("t5_tl", 50, 60, 1, 0);
        pix_at("t5_br", 53, 63, 1, 0);
        pix_at("t5_right", 54, 60, 0, 0);
        pix_at("t5_below", 50, 64, 0, 0);

        // Reset in the middle of an explosion
        cyc(1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b1, 1'b0);
        do_reset();
        cyc(1'b1, 1'b0, 1'b0);
        check_val("t6_fire", int'(shot_fired_o), 1);

        // Randomized traffic against the model
        for (int i = 0; i < 8000; i++) begin
            if ($urandom_range(0, 49) == 0)
                set_tank(int'($urandom_range(0, 624)), int'($urandom_range(0, 464)),
                         int'($urandom_range(0, 3)), ($urandom_range(0, 7) != 0));
            if ($urandom_range(0, 2999) == 0) do_reset();
            cyc(($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0),
                ($urandom_range(0, 39) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
